// File: rtl/counter_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : counter_ctrl_pkg
// Purpose : State encodings shared by counter_ctrl and the downstream run
//           counter, plus the speed-switch to interval selection helper.
// Ports   : (package - no ports)
// Revision: 1.0 - initial release
// ============================================================================
package counter_ctrl_pkg;

  // The downstream counter decodes these values, so they live here only.
  localparam logic [7:0] STATE_RESET = 8'd0;
  localparam logic [7:0] STATE_RUN   = 8'd1;
  localparam logic [7:0] STATE_HALT  = 8'd2;

  typedef enum logic [7:0] {
    ST_RESET = STATE_RESET,
    ST_RUN   = STATE_RUN,
    ST_HALT  = STATE_HALT
  } state_e;

  // Maps the synchronised speed switches onto one of four interval values.
  function automatic logic [31:0] select_interval(
    input logic [1:0]  sel,
    input logic [31:0] i0,
    input logic [31:0] i1,
    input logic [31:0] i2,
    input logic [31:0] i3
  );
    logic [31:0] v;
    case (sel)
      2'b00:   v = i0;
      2'b01:   v = i1;
      2'b10:   v = i2;
      default: v = i3;
    endcase
    return v;
  endfunction

endpackage : counter_ctrl_pkg
`default_nettype wire

// File: rtl/counter_ctrl_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module  : btn_debounce
// Purpose : Two-flop synchroniser, stability-counter debounce and registered
//           rising-edge pulse for one raw push button.
// Ports   : clk    - system clock
//           rst    - synchronous active-high reset
//           din    - raw asynchronous button input
//           level  - debounced button level
//           rise_p - one-cycle pulse after each debounced 0->1 transition
// Revision: 1.0 - initial release
// ============================================================================
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 32'd1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise_p
);

  // Wide enough to represent DEBOUNCE_CYCLES itself without wrapping.
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  // The counter is compared against D-1 so that the D-th consecutive
  // disagreeing sample flips the level on that same edge.
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_level_d;
  logic             r_rise;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_rise    <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1 <= din;
      r_sync2 <= r_sync1;

      if (r_sync2 != r_level) begin
        if (r_cnt == c_cnt_last) begin
          r_level <= ~r_level;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        // Any agreeing sample restarts the stability window.
        r_cnt <= '0;
      end

      r_level_d <= r_level;
      r_rise    <= r_level & ~r_level_d;
    end
  end

  assign level  = r_level;
  assign rise_p = r_rise;

endmodule : btn_debounce
`default_nettype wire

// File: rtl/counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : counter_ctrl
// Purpose : Button/switch front-end for the run counter. Debounces the start,
//           stop and clear buttons, runs the RESET/RUN/HALT state machine and
//           latches a switch-selected tick interval while not running.
// Ports   : clk       - system clock
//           rst       - synchronous active-high reset
//           btn_start - raw start/resume button
//           btn_stop  - raw halt button
//           btn_clear - raw clear button
//           sw_speed  - raw speed-select switches
//           state     - registered state to counter (0 RESET, 1 RUN, 2 HALT)
//           interval  - registered tick interval to counter
//           running   - registered, high iff state is RUN
// Revision: 1.0 - initial release
// ============================================================================
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 32'd1000000,
  parameter logic [31:0] INTERVAL0       = 32'd49999999,
  parameter logic [31:0] INTERVAL1       = 32'd24999999,
  parameter logic [31:0] INTERVAL2       = 32'd4999999,
  parameter logic [31:0] INTERVAL3       = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_start,
  input  logic        btn_stop,
  input  logic        btn_clear,
  input  logic [1:0]  sw_speed,
  output logic [7:0]  state,
  output logic [31:0] interval,
  output logic        running
);

  localparam int c_btn_start = 0;
  localparam int c_btn_stop  = 1;
  localparam int c_btn_clear = 2;

  logic [2:0]  w_btn_raw;
  logic [2:0]  w_rise;
  logic [2:0]  w_level_unused;   // debounced levels are not needed here
  state_e      w_next;

  state_e      r_state;
  logic        r_running;
  logic [31:0] r_interval;
  logic [1:0]  r_sw_sync1;
  logic [1:0]  r_sw_sync2;

  assign w_btn_raw = {btn_clear, btn_stop, btn_start};

  for (genvar gi = 0; gi < 3; gi++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk   (clk),
      .rst   (rst),
      .din   (w_btn_raw[gi]),
      .level (w_level_unused[gi]),
      .rise_p(w_rise[gi])
    );
  end

  // Next state: clear dominates, then stop, then start.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_RESET: if (w_rise[c_btn_start]) w_next = ST_RUN;
      ST_RUN:   if (w_rise[c_btn_stop])  w_next = ST_HALT;
      ST_HALT:  if (w_rise[c_btn_start]) w_next = ST_RUN;
      default:  w_next = ST_RESET;       // recover from illegal encodings
    endcase
    if (w_rise[c_btn_clear]) begin
      w_next = ST_RESET;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_RESET;
      r_running  <= 1'b0;
      r_interval <= INTERVAL0;
      r_sw_sync1 <= 2'b00;
      r_sw_sync2 <= 2'b00;
    end else begin
      r_sw_sync1 <= sw_speed;
      r_sw_sync2 <= r_sw_sync1;
      r_state    <= w_next;
      r_running  <= (w_next == ST_RUN);
      // Gated on the current state, so after RUN->HALT the new selection
      // lands one edge after HALT is entered.
      if (r_state != ST_RUN) begin
        r_interval <= select_interval(r_sw_sync2, INTERVAL0, INTERVAL1,
                                      INTERVAL2, INTERVAL3);
      end
    end
  end

  assign state    = r_state;
  assign interval = r_interval;
  assign running  = r_running;

endmodule : counter_ctrl
`default_nettype wire

// File: tb/tb_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_counter_ctrl
// Purpose : Self-checking bench for counter_ctrl with a short debounce window.
// Ports   : (none)
// Revision: 1.0 - initial release
// ============================================================================
module tb_counter_ctrl;
  import counter_ctrl_pkg::*;

  localparam int unsigned DB = 4;
  localparam logic [31:0] I0 = 32'd101;
  localparam logic [31:0] I1 = 32'd202;
  localparam logic [31:0] I2 = 32'd303;
  localparam logic [31:0] I3 = 32'd404;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_start = 1'b0;
  logic        btn_stop  = 1'b0;
  logic        btn_clear = 1'b0;
  logic [1:0]  sw_speed  = 2'b00;
  logic [7:0]  state;
  logic [31:0] interval;
  logic        running;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  counter_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .INTERVAL0(I0),
    .INTERVAL1(I1),
    .INTERVAL2(I2),
    .INTERVAL3(I3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_start(btn_start),
    .btn_stop (btn_stop),
    .btn_clear(btn_clear),
    .sw_speed (sw_speed),
    .state    (state),
    .interval (interval),
    .running  (running)
  );

  typedef struct {
    logic        st;
    logic        sp;
    logic        cl;
    logic [1:0]  sw;
    logic [7:0]  es;
    logic [31:0] ei;
    int          seg;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string name, input logic [7:0] es, input logic [31:0] ei);
    check({name, ".state"}, {24'd0, state}, {24'd0, es});
    check({name, ".interval"}, interval, ei);
    check({name, ".running"}, {31'd0, running}, {31'd0, (es == STATE_RUN)});
  endtask

  task automatic add(input logic st, input logic sp, input logic cl, input logic [1:0] sw,
                     input int n, input logic [7:0] es, input logic [31:0] ei, input int seg);
    vec_t v;
    v.st = st; v.sp = sp; v.cl = cl; v.sw = sw; v.es = es; v.ei = ei; v.seg = seg;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  // 6-cycle press then release; the new state is visible after edge 7.
  task automatic press(input logic st, input logic sp, input logic cl, input logic [1:0] sw,
                       input logic [7:0] os, input logic [7:0] ns, input logic [31:0] ei,
                       input int seg);
    add(st, sp, cl, sw, 6, os, ei, seg);
    add(1'b0, 1'b0, 1'b0, sw, 1, os, ei, seg);
    add(1'b0, 1'b0, 1'b0, sw, 9, ns, ei, seg);
  endtask

  initial begin
    int k;

    // Reset held 3 cycles, then idle 20 cycles.
    repeat (3) tick();
    check_all("reset", STATE_RESET, I0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_all("idle", STATE_RESET, I0);
    end

    // Vector table.
    press(1, 0, 0, 2'd0, STATE_RESET, STATE_RUN,   I0, 1);   // start latency
    add  (0, 1, 0, 2'd0, 3, STATE_RUN, I0, 2);              // stop glitch
    add  (0, 0, 0, 2'd0, 6, STATE_RUN, I0, 2);
    press(0, 1, 0, 2'd0, STATE_RUN,   STATE_HALT,  I0, 3);   // stop
    press(1, 0, 0, 2'd0, STATE_HALT,  STATE_RUN,   I0, 4);   // resume
    press(1, 1, 0, 2'd0, STATE_RUN,   STATE_HALT,  I0, 5);   // stop beats start
    press(1, 0, 1, 2'd0, STATE_HALT,  STATE_RESET, I0, 6);   // clear beats start
    press(0, 1, 0, 2'd0, STATE_RESET, STATE_RESET, I0, 7);   // stop ignored
    press(1, 0, 0, 2'd0, STATE_RESET, STATE_RUN,   I0, 8);
    add  (0, 0, 0, 2'd3, 6, STATE_RUN, I0, 9);              // frozen in RUN
    add  (0, 1, 0, 2'd3, 6, STATE_RUN, I0, 10);
    add  (0, 0, 0, 2'd3, 1, STATE_RUN, I0, 10);
    add  (0, 0, 0, 2'd3, 1, STATE_HALT, I0, 10);            // entry edge: still old
    add  (0, 0, 0, 2'd3, 8, STATE_HALT, I3, 10);            // one edge later: new
    press(0, 0, 1, 2'd3, STATE_HALT,  STATE_RESET, I3, 11);
    add  (0, 0, 0, 2'd1, 2, STATE_RESET, I3, 12);           // switch sync delay
    add  (0, 0, 0, 2'd1, 4, STATE_RESET, I1, 12);

    for (int i = 0; i < vecs.size(); i++) begin
      btn_start = vecs[i].st;
      btn_stop  = vecs[i].sp;
      btn_clear = vecs[i].cl;
      sw_speed  = vecs[i].sw;
      tick();
      check_all($sformatf("vec%0d_seg%0d", i, vecs[i].seg), vecs[i].es, vecs[i].ei);
    end

    // Reset while RUN with start held mid-debounce.
    btn_start = 1'b1;
    repeat (6) tick();
    btn_start = 1'b0;
    repeat (10) tick();
    check("midop_pre_run", {24'd0, state}, {24'd0, STATE_RUN});
    btn_start = 1'b1;
    repeat (3) tick();
    check("midop_held_run", {24'd0, state}, {24'd0, STATE_RUN});
    rst = 1'b1;
    btn_start = 1'b0;
    tick();
    check_all("midop_reset", STATE_RESET, I0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("midop_stay_reset", {24'd0, state}, {24'd0, STATE_RESET});
    end

    // Re-press: bounded wait for RUN, must arrive after edge DB+3.
    btn_start = 1'b1;
    k = -1;
    for (int e = 0; e < 20; e++) begin
      tick();
      if (state == STATE_RUN) begin
        k = e;
        break;
      end
    end
    check("repress_latency", k, DB + 3);
    check("repress_running", {31'd0, running}, 32'd1);
    btn_start = 1'b0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_counter_ctrl
`default_nettype wire
